cache_axi_bridge: RTL

- Sits directly downstream of the instruction and data caches and converts their single-word pulse handshakes into AXI3 master transactions on the SoC bus.
- One shared read path is arbitrated between instruction fetch and data load; a separate write path serves data stores.
- Single beat only, no bursts; at most one outstanding read and one outstanding write.

---
 rtl/cache_axi_bridge.sv | 281 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/cache_axi_bridge.sv
// Converts the I/D-cache single-word pulse handshakes into single-beat AXI3 master
// transactions: one arbitrated read path (data over instruction) and one store path.
module cache_axi_bridge #(
  parameter logic [3:0] INST_ARID = 4'd0,
  parameter logic [3:0] DATA_ARID = 4'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_interface_call_begin,
  input  logic [31:0] inst_interface_addr,
  output logic        inst_interface_return_ready,
  output logic [31:0] inst_interface_rdata,
  input  logic        data_interface_enable,
  input  logic        write_enable,
  input  logic [2:0]  read_size,
  input  logic [2:0]  write_size,
  input  logic [31:0] data_interface_raddr,
  input  logic [31:0] data_interface_waddr,
  input  logic [31:0] data_interface_wdata,
  input  logic        data_interface_call_begin,
  output logic        data_interface_return_ready,
  output logic [31:0] data_interface_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [1:0] {R_IDLE, R_AR, R_R} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_B} wr_state_t;

  function automatic logic [2:0] f_axsize(input logic [2:0] size);
    if (size[0])      return 3'd0;
    else if (size[1]) return 3'd1;
    else              return 3'd2;
  endfunction

  function automatic logic [3:0] f_wstrb(input logic [2:0] size, input logic [1:0] addr);
    if (size[0])      return 4'b0001 << addr;
    else if (size[1]) return addr[1] ? 4'b1100 : 4'b0011;
    else              return 4'b1111;
  endfunction

  rd_state_t   r_rd_state;
  wr_state_t   r_wr_state;
  logic        r_rd_is_data;
  logic        r_inst_pend, r_dr_pend, r_dw_pend;
  logic [31:0] r_inst_addr, r_dr_addr, r_dw_addr, r_dw_wdata;
  logic [2:0]  r_dr_size, r_dw_size;
  logic        r_inst_ready, r_data_rd_ready, r_data_wr_ready;
  logic [31:0] r_inst_rdata, r_data_rdata;
  logic [3:0]  r_arid, r_awid, r_wid, r_wstrb;
  logic [31:0] r_araddr, r_awaddr, r_wdata;
  logic [2:0]  r_arsize, r_awsize;
  logic        r_arvalid, r_rready, r_awvalid, r_wvalid, r_bready;

  // A pulse arriving while idle is launched straight away, so the request seen by
  // the FSMs merges the live pulse with the latched pending copy.
  logic        w_inst_new, w_dr_new, w_dw_new;
  logic        w_inst_req, w_dr_req, w_dw_req;
  logic [31:0] w_inst_addr, w_dr_addr, w_dw_addr, w_dw_wdata;
  logic [2:0]  w_dr_size, w_dw_size;
  logic        w_unused;

  assign w_inst_new  = inst_interface_call_begin & ~r_inst_pend;
  assign w_dr_new    = data_interface_call_begin & ~write_enable & ~r_dr_pend;
  assign w_dw_new    = data_interface_call_begin &  write_enable & ~r_dw_pend;
  assign w_inst_req  = r_inst_pend | w_inst_new;
  assign w_dr_req    = r_dr_pend | w_dr_new;
  assign w_dw_req    = r_dw_pend | w_dw_new;
  assign w_inst_addr = r_inst_pend ? r_inst_addr : inst_interface_addr;
  assign w_dr_addr   = r_dr_pend ? r_dr_addr : data_interface_raddr;
  assign w_dr_size   = r_dr_pend ? r_dr_size : read_size;
  assign w_dw_addr   = r_dw_pend ? r_dw_addr : data_interface_waddr;
  assign w_dw_size   = r_dw_pend ? r_dw_size : write_size;
  assign w_dw_wdata  = r_dw_pend ? r_dw_wdata : data_interface_wdata;
  assign w_unused    = &{1'b0, data_interface_enable, rid, rresp, rlast, bid, bresp};

  // NOTE: every state register below uses non-blocking assignment so that all
  // flops update together from pre-edge values; blocking here would create races.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_state      <= R_IDLE;
      r_rd_is_data    <= 1'b0;
      r_inst_pend     <= 1'b0;
      r_dr_pend       <= 1'b0;
      r_inst_addr     <= '0;
      r_dr_addr       <= '0;
      r_dr_size       <= '0;
      r_inst_ready    <= 1'b0;
      r_data_rd_ready <= 1'b0;
      r_inst_rdata    <= '0;
      r_data_rdata    <= '0;
      r_arid          <= '0;
      r_araddr        <= '0;
      r_arsize        <= '0;
      r_arvalid       <= 1'b0;
      r_rready        <= 1'b0;
    end else begin
      r_inst_ready    <= 1'b0;
      r_data_rd_ready <= 1'b0;
      if (w_inst_new) begin
        r_inst_pend <= 1'b1;
        r_inst_addr <= inst_interface_addr;
      end
      if (w_dr_new) begin
        r_dr_pend <= 1'b1;
        r_dr_addr <= data_interface_raddr;
        r_dr_size <= read_size;
      end
      case (r_rd_state)
        R_IDLE: begin
          if (w_dr_req) begin
            r_rd_is_data <= 1'b1;
            r_arid       <= DATA_ARID;
            r_araddr     <= w_dr_addr;
            r_arsize     <= f_axsize(w_dr_size);
            r_arvalid    <= 1'b1;
            r_rd_state   <= R_AR;
          end else if (w_inst_req) begin
            r_rd_is_data <= 1'b0;
            r_arid       <= INST_ARID;
            r_araddr     <= w_inst_addr;
            r_arsize     <= 3'd2;
            r_arvalid    <= 1'b1;
            r_rd_state   <= R_AR;
          end
        end
        R_AR: begin
          if (arready) begin
            r_arvalid  <= 1'b0;
            r_rready   <= 1'b1;
            r_rd_state <= R_R;
          end
        end
        R_R: begin
          if (rvalid) begin
            r_rready   <= 1'b0;
            r_rd_state <= R_IDLE;
            if (r_rd_is_data) begin
              r_data_rdata    <= rdata;
              r_data_rd_ready <= 1'b1;
              r_dr_pend       <= 1'b0;
            end else begin
              r_inst_rdata <= rdata;
              r_inst_ready <= 1'b1;
              r_inst_pend  <= 1'b0;
            end
          end
        end
        default: r_rd_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_state      <= W_IDLE;
      r_dw_pend       <= 1'b0;
      r_dw_addr       <= '0;
      r_dw_size       <= '0;
      r_dw_wdata      <= '0;
      r_data_wr_ready <= 1'b0;
      r_awid          <= '0;
      r_wid           <= '0;
      r_awaddr        <= '0;
      r_awsize        <= '0;
      r_wdata         <= '0;
      r_wstrb         <= '0;
      r_awvalid       <= 1'b0;
      r_wvalid        <= 1'b0;
      r_bready        <= 1'b0;
    end else begin
      r_data_wr_ready <= 1'b0;
      if (w_dw_new) begin
        r_dw_pend  <= 1'b1;
        r_dw_addr  <= data_interface_waddr;
        r_dw_size  <= write_size;
        r_dw_wdata <= data_interface_wdata;
      end
      case (r_wr_state)
        W_IDLE: begin
          if (w_dw_req) begin
            r_awid     <= DATA_ARID;
            r_wid      <= DATA_ARID;
            r_awaddr   <= w_dw_addr;
            r_awsize   <= f_axsize(w_dw_size);
            r_wdata    <= w_dw_wdata;
            r_wstrb    <= f_wstrb(w_dw_size, w_dw_addr[1:0]);
            r_awvalid  <= 1'b1;
            r_wvalid   <= 1'b1;
            r_wr_state <= W_REQ;
          end
        end
        W_REQ: begin
          if (awready) r_awvalid <= 1'b0;
          if (wready)  r_wvalid  <= 1'b0;
          // Either channel may already have completed in an earlier cycle.
          if ((~r_awvalid | awready) & (~r_wvalid | wready)) begin
            r_bready   <= 1'b1;
            r_wr_state <= W_B;
          end
        end
        W_B: begin
          if (bvalid) begin
            r_bready        <= 1'b0;
            r_data_wr_ready <= 1'b1;
            r_dw_pend       <= 1'b0;
            r_wr_state      <= W_IDLE;
          end
        end
        default: r_wr_state <= W_IDLE;
      endcase
    end
  end

  assign inst_interface_return_ready = r_inst_ready;
  assign inst_interface_rdata        = r_inst_rdata;
  assign data_interface_return_ready = r_data_rd_ready | r_data_wr_ready;
  assign data_interface_rdata        = r_data_rdata;

  assign arid    = r_arid;
  assign araddr  = r_araddr;
  assign arlen   = 4'd0;
  assign arsize  = r_arsize;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign arvalid = r_arvalid;
  assign rready  = r_rready;

  assign awid    = r_awid;
  assign awaddr  = r_awaddr;
  assign awlen   = 4'd0;
  assign awsize  = r_awsize;
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign awvalid = r_awvalid;
  assign wid     = r_wid;
  assign wdata   = r_wdata;
  assign wstrb   = r_wstrb;
  assign wlast   = 1'b1;
  assign wvalid  = r_wvalid;
  assign bready  = r_bready;

endmodule
